// File: rtl/mul_unit_if.sv
// Operand/result bundle for the pipelined 32x32 multiplier.
// The issuing stage holds the master side and the multiplier holds the slave side.
interface mul_unit_if;
    logic        in_valid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        sgn1;
    logic        sgn2;
    logic        out_valid;
    logic [31:0] out_hi;
    logic [31:0] out_lo;

    modport master (output in_valid, in1, in2, sgn1, sgn2,
                    input  out_valid, out_hi, out_lo);
    modport slave  (input  in_valid, in1, in2, sgn1, sgn2,
                    output out_valid, out_hi, out_lo);
endinterface

// File: rtl/mul_unit.sv
// Fixed 9-cycle, fully pipelined 32x32->64 multiplier. Sign and magnitude are split
// at the input, the magnitudes are multiplied four multiplier bits per stage, and the
// sign is applied at the output.
module mul_pp (
    input  logic [31:0] mag,
    input  logic [3:0]  nib,
    output logic [35:0] pp
);
    always_comb begin
        pp = '0;
        for (int b = 0; b < 4; b++)
            if (nib[b]) pp = pp + ({4'b0, mag} << b);
    end
endmodule

module mul_unit (
    input  logic      clk,
    input  logic      rst,
    mul_unit_if.slave bus
);
    localparam int STAGES = 8;
    localparam int REM_W  = 4 * 36;

    // Unconsumed multiplier nibbles, packed as a triangle. After stage s there are
    // 8-s nibbles left, so every stored bit is used later in the pipe.
    function automatic int rem_off(input int s);
        return 4 * (8 * s - (s * (s - 1)) / 2);
    endfunction

    logic                     neg1, neg2;
    logic [31:0]              mag1, mag2;
    logic [STAGES-1:0][31:0]  mag1_p;
    logic [REM_W-1:0]         rem;
    logic [STAGES:1][63:0]    acc_p;
    logic [STAGES:0]          np_p;
    logic [STAGES:0]          vld_pipe;
    logic [63:0]              product;

    always_comb begin
        neg1 = bus.sgn1 & bus.in1[31];
        neg2 = bus.sgn2 & bus.in2[31];
        mag1 = neg1 ? -bus.in1 : bus.in1;
        mag2 = neg2 ? -bus.in2 : bus.in2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag1_p[0]   <= '0;
            rem[31:0]   <= '0;
            np_p[0]     <= 1'b0;
            vld_pipe[0] <= 1'b0;
        end else begin
            mag1_p[0]   <= mag1;
            rem[31:0]   <= mag2;
            np_p[0]     <= neg1 ^ neg2;
            vld_pipe[0] <= bus.in_valid;
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int OFF_IN = rem_off(k - 1);
        logic [35:0] pp;
        logic [63:0] sum;

        mul_pp u_pp (.mag(mag1_p[k-1]), .nib(rem[OFF_IN +: 4]), .pp(pp));

        if (k == 1) begin : g_first
            assign sum = {28'd0, pp};
        end else begin : g_rest
            assign sum = acc_p[k-1] + ({28'd0, pp} << (4 * (k - 1)));
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_p[k]    <= '0;
                np_p[k]     <= 1'b0;
                vld_pipe[k] <= 1'b0;
            end else begin
                acc_p[k]    <= sum;
                np_p[k]     <= np_p[k-1];
                vld_pipe[k] <= vld_pipe[k-1];
            end
        end

        // The last stage has no successor, so mag1 and the leftover nibbles stop here.
        if (k < STAGES) begin : g_fwd
            localparam int OFF_OUT = rem_off(k);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mag1_p[k]                             <= '0;
                    rem[OFF_OUT +: 4*(STAGES-k)]          <= '0;
                end else begin
                    mag1_p[k]                             <= mag1_p[k-1];
                    rem[OFF_OUT +: 4*(STAGES-k)]          <= rem[OFF_IN+4 +: 4*(STAGES-k)];
                end
            end
        end
    end

    // A zero magnitude negates to zero, so no -0 special case is needed.
    assign product       = np_p[STAGES] ? -acc_p[STAGES] : acc_p[STAGES];
    assign bus.out_hi    = product[63:32];
    assign bus.out_lo    = product[31:0];
    assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_mul_unit.sv
// Directed and randomized checks of mul_unit: sign combinations, corners, streaming
// with gaps, reset mid-flight, and a short random run against a 64-bit product.
module tb_mul_unit;
    logic clk;
    logic rst;
    mul_unit_if bus ();

    mul_unit dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        chk;
        logic [63:0] p;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // After reset the stage-8 register is zero for eight edges before new data lands.
    task automatic prefill();
        exp_t e;
        q.delete();
        e.v = 1'b0; e.chk = 1'b1; e.p = 64'd0;
        repeat (8) q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s1, input logic s2, input logic [63:0] p);
        exp_t e;
        bus.in_valid = v; bus.in1 = a; bus.in2 = b; bus.sgn1 = s1; bus.sgn2 = s2;
        e.v = v; e.chk = v; e.p = p;
        q.push_back(e);
        @(posedge clk); #1;
        if (q.size() == 9) begin
            e = q.pop_front();
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, e.v});
            if (e.chk) chk("product", {bus.out_hi, bus.out_lo}, e.p);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic rnd_op(input logic v);
        logic [31:0] a, b;
        logic s1, s2;
        a = $urandom; b = $urandom; s1 = 1'($urandom); s2 = 1'($urandom);
        step(v, a, b, s1, s2, ref_mul(a, b, s1, s2));
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.sgn1 = 1'b0; bus.sgn2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset product", {bus.out_hi, bus.out_lo}, 64'd0);
        rst = 1'b0;
        prefill();

        // Single unsigned max, then idles so out_valid must be a one-cycle pulse.
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        idle(10);

        // Sign combinations and corners, back to back.
        step(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        step(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        step(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 64'h0000_0006_FFFF_FFEB);
        step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
        step(1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 64'h0000_0000_0000_0000);
        step(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_8000_0000);
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
        step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'h4000_0000_0000_0000);
        step(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_0000);
        idle(9);

        // Streaming: 20 ops, 3-cycle gap, 5 ops.
        for (int i = 0; i < 20; i++) rnd_op(1'b1);
        idle(3);
        for (int i = 0; i < 5; i++) rnd_op(1'b1);
        idle(9);

        // Reset mid-flight: the burst is cut off on its fourth cycle and nothing emerges.
        for (int i = 0; i < 3; i++) rnd_op(1'b1);
        bus.in_valid = 1'b1; bus.in1 = 32'h1234_5678; bus.in2 = 32'h9ABC_DEF0;
        rst = 1'b1;
        #1;
        chk("midflight reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midflight reset product", {bus.out_hi, bus.out_lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        prefill();
        idle(4);
        step(1'b1, 32'd12345, 32'd678, 1'b0, 1'b0, 64'd8369910);
        idle(12);

        // Random regression with toggling in_valid.
        for (int i = 0; i < 300; i++) rnd_op(1'($urandom_range(0, 3) != 0));
        idle(9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
